dose_log_uart_tx: RTL and testbench
===================================

Name: dose_log_uart_tx

Overview:
Read-side counterpart to the dose logger. It buffers dose-event log bytes written by the scheduler/logger in a 16-entry FIFO. On request, it drains the buffered entries to the host over a UART 8N1 serial line as a framed dump: header, entries, XOR checksum. It sits between the logger write strobe and a uio output pin of the top level.

Parameters:
DEPTH, 16, FIFO entries (power of two)
ADDR_W, 4, log2(DEPTH)
CLKS_PER_BIT, 16, clk cycles per UART bit (>=2)
HEADER, 8'hA5, first byte of every dump

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
log_wr  input  1  write strobe; one entry per cycle high
log_data  input  8  log entry written when log_wr=1
dump_req  input  1  start a dump; sampled only in IDLE
clear  input  1  synchronous FIFO flush and overflow clear
tx  output  1  UART serial out, idle high
busy  output  1  dump in progress
fifo_count  output  ADDR_W+1  entries held, 0..DEPTH
overflow  output  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset (async): tx=1, busy=0, fifo_count=0, overflow=0, FIFO empty, FSM=IDLE, bit/baud counters 0. Reset mid-frame aborts the frame immediately, and tx returns high.
- Write side: on log_wr=1 with count<DEPTH, store log_data at wr_ptr; wr_ptr wraps DEPTH-1->0. With count==DEPTH, drop the write and set overflow=1. Fullness is evaluated on the pre-edge count, so a pop in the same cycle does not rescue the write.
- Simultaneous write and pop: count is unchanged; both take effect.
- clear: acted on only when busy=0. It empties the FIFO (pointers and count to 0) and clears overflow. If clear and log_wr are both high, clear wins and the write is dropped without setting overflow. clear while busy=1 is ignored.
- Dump sequence: when dump_req=1 in IDLE, latch N=fifo_count, zero the checksum, set busy=1 next cycle, and send these frames back-to-back with no idle gap:
  1. HEADER.
  2. N entries in FIFO order.
  3. Checksum = XOR of the N entries (0x00 if N=0).
- Popping: each entry is popped, and its value XORed into the checksum, in the cycle its frame is loaded. Entries written during a dump stay in the FIFO for the next dump.
- dump_req while busy is ignored (not queued).
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles. tx is driven from a register.
- FSM:
  - IDLE -> START on dump_req.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if frames remain, else DONE.
  - DONE -> IDLE in one cycle, with busy=0 from that edge.
- Dump timing: tx falls on the first clk edge after dump_req is sampled. busy deasserts 1 cycle after the final stop bit completes. Total busy time = (N+2)*10*CLKS_PER_BIT + 1 cycles.
- Counters: the baud counter runs 0..CLKS_PER_BIT-1 and wraps. The bit index runs 0..7. The frame counter is ADDR_W+2 bits wide, so it covers N+2 <= 18.

Test Plan:
1. CLKS_PER_BIT=4; write 0x11, 0x22, 0x44; pulse dump_req -> tx sends A5, 11, 22, 44, 77. Each frame is 40 cycles. busy is high 201 cycles; fifo_count ends at 0.
2. Empty FIFO dump -> frames A5, 00. busy is high 81 cycles; overflow stays 0.
3. Write 17 entries 0x00..0x10 -> fifo_count=16, overflow=1. Dump sends A5, 00..0F, then checksum 0x00. overflow stays 1 until clear, which brings count=0 and overflow=0.
4. During a dump of 2 entries, write 0x5A and pulse dump_req again -> the dump sends only A5 plus the 2 entries plus the checksum. The second dump_req is ignored, and afterwards fifo_count=1.
5. Assert rst_n=0 mid data-bit of the second frame -> tx=1, busy=0, fifo_count=0 within the same cycle. After release, tx stays idle high.
6. Pulse clear and log_wr together in IDLE -> fifo_count unchanged from 0 and overflow=0. Pulse clear while busy -> no effect on the in-flight dump.

Source files
------------

// File: rtl/dose_log_uart_tx.sv
// Dose-log dump transmitter. Log bytes are buffered in a small FIFO. On
// dump_req, the buffered bytes are sent over a UART 8N1 line as one framed
// dump: a header byte, then the buffered entries in FIFO order, then the XOR
// checksum of those entries.
module dose_log_uart_tx #(
  parameter int          DEPTH        = 16,
  parameter int          ADDR_W       = 4,
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              log_wr,
  input  logic [7:0]        log_data,
  input  logic              dump_req,
  input  logic              clear,
  output logic              tx,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam int FRAME_W = ADDR_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q;
  logic [2:0]          bit_q;
  logic [FRAME_W-1:0]  frame_q;      // index of the frame on the line
  logic [ADDR_W:0]     n_q;          // entry count latched at dump start
  logic [7:0]          csum_q;
  logic [7:0]          sh_q;         // byte of the frame on the line
  logic                tx_q;

  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     count_q;
  logic                ovf_q;

  logic                baud_end, last_frame, more_entries;
  logic                start_dump, next_frame, pop;
  logic                clear_eff, full, wr_ok;
  logic [7:0]          rd_data;

  assign baud_end     = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  // Frames run 0 = header, 1..N = entries, N+1 = checksum.
  assign last_frame   = (frame_q == FRAME_W'(n_q) + FRAME_W'(1));
  assign more_entries = (frame_q < FRAME_W'(n_q));
  assign rd_data      = mem[rd_ptr_q];

  assign clear_eff = clear && (state_q == S_IDLE);
  assign full      = (count_q == (ADDR_W+1)'(DEPTH));
  assign wr_ok     = log_wr && !clear_eff && !full;

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from pre-edge values, independent of block order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    start_dump = 1'b0;
    next_frame = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE:  if (dump_req) begin
                 state_d    = S_START;
                 start_dump = 1'b1;
               end
      S_START: if (baud_end) state_d = S_DATA;
      S_DATA:  if (baud_end && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (baud_end) begin
                 if (last_frame) begin
                   state_d = S_DONE;
                 end else begin
                   state_d    = S_START;
                   next_frame = 1'b1;
                   pop        = more_entries;
                 end
               end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Serializer: baud/bit/frame counters, frame loading, checksum, tx register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q  <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      n_q     <= '0;
      csum_q  <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      if (state_q == S_START || state_q == S_DATA || state_q == S_STOP)
        baud_q <= baud_end ? '0 : baud_q + BAUD_W'(1);
      else
        baud_q <= '0;

      if (start_dump) begin
        tx_q    <= 1'b0;
        sh_q    <= HEADER;
        frame_q <= '0;
        n_q     <= count_q;
        csum_q  <= '0;
      end

      if (state_q == S_START && baud_end) begin
        tx_q  <= sh_q[0];
        bit_q <= '0;
      end

      if (state_q == S_DATA && baud_end) begin
        if (bit_q == 3'd7) begin
          tx_q <= 1'b1;
        end else begin
          tx_q  <= sh_q[bit_q + 3'd1];
          bit_q <= bit_q + 3'd1;
        end
      end

      if (next_frame) begin
        tx_q    <= 1'b0;
        frame_q <= frame_q + FRAME_W'(1);
        sh_q    <= pop ? rd_data : csum_q;
      end

      if (pop) csum_q <= csum_q ^ rd_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (clear_eff) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ok)         wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)           rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      if (log_wr && full) ovf_q   <= 1'b1;
      case ({wr_ok, pop})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers and count define which
    // entries are valid, so resetting the array would only add reset fan-out.
    if (wr_ok) mem[wr_ptr_q] <= log_data;
  end

endmodule

// File: tb/tb_dose_log_uart_tx.sv
// Bench for dose_log_uart_tx: a queue models the FIFO, expected dump bytes are
// queued when a dump is requested, and a UART receiver pops and compares them.
module tb_dose_log_uart_tx;

  localparam int CPB    = 4;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              log_wr = 1'b0;
  logic [7:0]        log_data = 8'h00;
  logic              dump_req = 1'b0;
  logic              clear = 1'b0;
  logic              tx, busy, overflow;
  logic [ADDR_W:0]   fifo_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0       = 0;
  int exp_n    = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];

  dose_log_uart_tx #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLKS_PER_BIT(CPB), .HEADER(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .log_wr(log_wr), .log_data(log_data),
    .dump_req(dump_req), .clear(clear), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // UART receiver: samples mid-bit on the falling clock edge.
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  int         rx_bit = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        rx_bit = rx_cnt / CPB;
        if (rx_bit >= 1 && rx_bit <= 8) begin
          rx_byte[rx_bit-1] = tx;
        end else if (rx_bit == 9) begin
          check("stop_bit", 32'(tx), 32'd1);
          if (exp_q.size() == 0) check("unexpected_frame", 32'(rx_byte), 32'h100);
          else                   check("frame_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic wr(input logic [7:0] b);
    @(negedge clk);
    log_wr   = 1'b1;
    log_data = b;
    if (model_q.size() < DEPTH) model_q.push_back(b);
    @(negedge clk);
    log_wr = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic start_dump();
    logic [7:0] cs;
    logic [7:0] b;
    @(negedge clk);
    dump_req = 1'b1;
    exp_n = model_q.size();
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    for (int i = 0; i < exp_n; i++) begin
      b = model_q.pop_front();
      exp_q.push_back(b);
      cs ^= b;
    end
    exp_q.push_back(cs);
    @(posedge clk);
    #1;
    t0 = cyc;
    check("tx_falls_first_edge", 32'(tx), 32'd0);
    check("busy_rises", 32'(busy), 32'd1);
    @(negedge clk);
    dump_req = 1'b0;
  endtask

  task automatic wait_dump(input string tag);
    while (busy === 1'b1 && (cyc - t0) < 3000) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_busy_len"}, 32'(cyc - t0), 32'((exp_n + 2) * 10 * CPB + 1));
    check({tag, "_frames_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_low;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // Three entries: A5 11 22 44 77.
    wr(8'h11); wr(8'h22); wr(8'h44);
    check("t1_count", 32'(fifo_count), 32'd3);
    start_dump();
    wait_dump("t1");
    check("t1_count_end", 32'(fifo_count), 32'd0);
    check("t1_ovf", 32'(overflow), 32'd0);

    // Empty dump: A5 00.
    start_dump();
    wait_dump("t2");
    check("t2_ovf", 32'(overflow), 32'd0);

    // Overflow: 17 writes, 16 kept.
    for (int i = 0; i < 17; i++) wr(8'(i));
    check("t3_count_full", 32'(fifo_count), 32'd16);
    check("t3_ovf_set", 32'(overflow), 32'd1);
    start_dump();
    wait_dump("t3");
    check("t3_ovf_sticky", 32'(overflow), 32'd1);
    check("t3_count_end", 32'(fifo_count), 32'd0);
    wr(8'h01); wr(8'h02);
    pulse_clear();
    model_q.delete();
    check("t3_clear_count", 32'(fifo_count), 32'd0);
    check("t3_clear_ovf", 32'(overflow), 32'd0);

    // Write and a second dump_req during a dump.
    wr(8'hC3); wr(8'h3C);
    start_dump();
    wr(8'h5A);
    @(negedge clk); dump_req = 1'b1;
    @(negedge clk); dump_req = 1'b0;
    wait_dump("t4");
    check("t4_count_left", 32'(fifo_count), 32'd1);
    repeat (5) @(negedge clk);
    check("t4_req_ignored", 32'(busy), 32'd0);

    // Reset in a data bit of the second frame.
    wr(8'h81);
    start_dump();
    while (cyc < t0 + 10 * CPB + 2 * CPB + 1) begin
      @(posedge clk);
      #1;
    end
    check("t5_in_frame2", 32'(busy), 32'd1);
    exp_q.delete();
    model_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx", 32'(tx), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_count", 32'(fifo_count), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("t5_tx_idle", 32'(saw_low), 32'd0);
    check("t5_busy_idle", 32'(busy), 32'd0);

    // clear beats a simultaneous write.
    @(negedge clk);
    clear = 1'b1; log_wr = 1'b1; log_data = 8'h77;
    @(negedge clk);
    clear = 1'b0; log_wr = 1'b0;
    check("t6_clear_wr_count", 32'(fifo_count), 32'd0);
    check("t6_clear_wr_ovf", 32'(overflow), 32'd0);

    // clear during a dump is ignored.
    wr(8'h0F); wr(8'hF0);
    start_dump();
    wr(8'h33);
    pulse_clear();
    wait_dump("t6");
    check("t6_count_kept", 32'(fifo_count), 32'd1);
    check("t6_ovf", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
